esptype_arbiter: RTL and testbench

- Arbitrates ESP-type change requests from NUM_REQ requesters and sequences the 2-bit ESP-type output PIO register through its Avalon-MM slave port.
- Each change is one write to PIO address 0, followed by a programmable settle interval for the external mux to stabilise.
- Sits between requesting control blocks and the PIO. Only this block is allowed to write the PIO.

---
 rtl/esptype_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_esptype_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esptype_arbiter.sv
// Round-robin arbiter that sequences ESP-type changes into a 2-bit Avalon-MM PIO.
// Optional PIO readback verify: define ESPTYPE_ARB_READBACK_EN.
module esptype_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_type,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic [1:0]           cur_type,
    output logic [1:0]           m_address,
    output logic                 m_chipselect,
    output logic                 m_write_n,
`ifdef ESPTYPE_ARB_READBACK_EN
    output logic [31:0]          m_writedata,
    input  logic [31:0]          m_readdata,
    output logic                 rb_error
`else
    output logic [31:0]          m_writedata
`endif
);

    localparam int PW = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [15:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? 16'(SETTLE_CYCLES - 1) : 16'd0;

`ifdef ESPTYPE_ARB_READBACK_EN
    typedef enum logic [2:0] {
        IDLE, WRITE, READBACK, RB_CHECK, SETTLE, DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, WRITE, SETTLE, DONE
    } state_t;
`endif

    state_t             state, state_nx;
    logic [PW-1:0]      ptr, ptr_nx;
    logic [PW-1:0]      win, win_nx;
    logic [PW-1:0]      pick;
    logic               found;
    int                 idx;
    logic [1:0]         pick_type;
    logic [1:0]         typ, typ_nx;
    logic [15:0]        cnt, cnt_nx;
    logic [NUM_REQ-1:0] grant_nx, done_nx;
    logic               busy_nx, cs_nx, wn_nx;
    logic [1:0]         cur_nx;
    logic [31:0]        wd_nx;
`ifdef ESPTYPE_ARB_READBACK_EN
    logic               rb_nx;
`endif

    assign m_address = 2'b00;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    assign pick_type = req_type[{pick, 1'b0} +: 2];

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        win_nx   = win;
        typ_nx   = typ;
        cnt_nx   = cnt;
        cur_nx   = cur_type;
        grant_nx = grant;
        cs_nx    = 1'b0;
        wn_nx    = 1'b1;
        wd_nx    = m_writedata;
`ifdef ESPTYPE_ARB_READBACK_EN
        rb_nx    = rb_error;
`endif
        unique case (state)
            IDLE: begin
                if (|req) begin
                    win_nx   = pick;
                    typ_nx   = pick_type;
                    grant_nx = NUM_REQ'(1) << pick;
                    if (pick_type == cur_type) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = WRITE;
                        cs_nx    = 1'b1;
                        wn_nx    = 1'b0;
                        wd_nx    = {30'b0, pick_type};
                    end
                end
            end
            WRITE: begin
                cur_nx = typ;
`ifdef ESPTYPE_ARB_READBACK_EN
                state_nx = READBACK;
                cs_nx    = 1'b1;
`else
                if (SETTLE_CYCLES > 0) begin
                    state_nx = SETTLE;
                    cnt_nx   = SETTLE_LOAD;
                end else begin
                    state_nx = DONE;
                end
`endif
            end
`ifdef ESPTYPE_ARB_READBACK_EN
            READBACK: begin
                state_nx = RB_CHECK;
            end
            RB_CHECK: begin
                // Read data returns one cycle after the read strobe.
                if (m_readdata[1:0] != typ) begin
                    rb_nx = 1'b1;
                end
                if (SETTLE_CYCLES > 0) begin
                    state_nx = SETTLE;
                    cnt_nx   = SETTLE_LOAD;
                end else begin
                    state_nx = DONE;
                end
            end
`endif
            SETTLE: begin
                if (cnt == 16'd0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                grant_nx = '0;
                ptr_nx   = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
        done_nx = (state_nx == DONE) ? grant_nx : '0;
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            win          <= '0;
            typ          <= 2'b00;
            cnt          <= 16'd0;
            grant        <= '0;
            done         <= '0;
            busy         <= 1'b0;
            cur_type     <= 2'b00;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= 32'd0;
        end else begin
            state        <= state_nx;
            ptr          <= ptr_nx;
            win          <= win_nx;
            typ          <= typ_nx;
            cnt          <= cnt_nx;
            grant        <= grant_nx;
            done         <= done_nx;
            busy         <= busy_nx;
            cur_type     <= cur_nx;
            m_chipselect <= cs_nx;
            m_write_n    <= wn_nx;
            m_writedata  <= wd_nx;
        end
    end

`ifdef ESPTYPE_ARB_READBACK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb_error <= 1'b0;
        end else begin
            rb_error <= rb_nx;
        end
    end
`endif

endmodule

// File: tb/tb_esptype_arbiter.sv
// Bench for esptype_arbiter: service-timeline model plus directed literal checks.
`timescale 1ns/1ps
module tb_esptype_arbiter;

    localparam int N = 2;
    localparam int S = 4;
`ifdef ESPTYPE_ARB_READBACK_EN
    localparam int RBX = 2;
`else
    localparam int RBX = 0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [2*N-1:0] req_type = '0;
    logic [N-1:0]   grant, done;
    logic           busy;
    logic [1:0]     cur_type, m_address;
    logic           m_chipselect, m_write_n;
    logic [31:0]    m_writedata;

    logic [1:0]     req_b = '0;
    logic [3:0]     type_b = '0;
    logic [1:0]     grant_b, done_b;
    logic           busy_b;
    logic [1:0]     cur_b, addr_b;
    logic           cs_b, wn_b;
    logic [31:0]    wd_b;

    bit             rb_fault = 1'b0;
    int             vectors = 0;
    int             errs = 0;
    int             cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef ESPTYPE_ARB_READBACK_EN
    logic [31:0] m_readdata;
    logic [31:0] rd_b;
    logic        rb_error, rb_err_b;
    logic [1:0]  pio;
    logic [31:0] rd;

    // PIO slave: read data one cycle after the read strobe, optionally corrupted.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pio <= 2'b00;
            rd  <= 32'd0;
        end else begin
            if (m_chipselect && !m_write_n) pio <= m_writedata[1:0];
            if (m_chipselect && m_write_n) rd <= rb_fault ? 32'd0 : {30'd0, pio};
        end
    end
    assign m_readdata = rd;
    assign rd_b = 32'd1;

    esptype_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .req(req), .req_type(req_type),
        .grant(grant), .done(done), .busy(busy), .cur_type(cur_type),
        .m_address(m_address), .m_chipselect(m_chipselect),
        .m_write_n(m_write_n), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .rb_error(rb_error)
    );
    esptype_arbiter #(.NUM_REQ(2), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req_b), .req_type(type_b),
        .grant(grant_b), .done(done_b), .busy(busy_b), .cur_type(cur_b),
        .m_address(addr_b), .m_chipselect(cs_b),
        .m_write_n(wn_b), .m_writedata(wd_b),
        .m_readdata(rd_b), .rb_error(rb_err_b)
    );
`else
    esptype_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .req(req), .req_type(req_type),
        .grant(grant), .done(done), .busy(busy), .cur_type(cur_type),
        .m_address(m_address), .m_chipselect(m_chipselect),
        .m_write_n(m_write_n), .m_writedata(m_writedata)
    );
    esptype_arbiter #(.NUM_REQ(2), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req_b), .req_type(type_b),
        .grant(grant_b), .done(done_b), .busy(busy_b), .cur_type(cur_b),
        .m_address(addr_b), .m_chipselect(cs_b),
        .m_write_n(wn_b), .m_writedata(wd_b)
    );
`endif

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string n);
        vectors++;
        errs++;
        $display("FAIL %s: no response within cycle budget (cycle %0d)", n, cyc);
    endtask

    // Model: each service is a timeline of mlen cycles after the grant edge.
    bit         mb;
    int         mw, mc, mlen, mptr;
    logic [1:0] mt, mcur, mprev;
    bit         mskip, mrb;
    int         nw;
    logic [1:0] nt;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    assign nw = rr_pick(req, mptr);
    assign nt = req_type[2*nw +: 2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mb <= 1'b0; mw <= 0; mc <= 0; mlen <= 0; mptr <= 0;
            mt <= 2'b00; mcur <= 2'b00; mprev <= 2'b00;
            mskip <= 1'b0; mrb <= 1'b0;
        end else if (mb) begin
            if (mc == mlen - 1) begin
                mb   <= 1'b0;
                mptr <= (mw + 1) % N;
            end else begin
                mc <= mc + 1;
            end
            if (RBX > 0 && !mskip && mc == 2 && rb_fault && mt != 2'b00) mrb <= 1'b1;
        end else if (|req) begin
            mb    <= 1'b1;
            mc    <= 0;
            mw    <= nw;
            mt    <= nt;
            mprev <= mcur;
            mcur  <= nt;
            mskip <= (nt == mcur);
            mlen  <= (nt == mcur) ? 1 : 2 + RBX + S;
        end
    end

    logic [31:0] wr_log[$];
    logic [31:0] done_log[$];
    int          wr_cyc = -1;
    int          done_cyc = -1;

    always @(negedge clk) begin
        if (!reset) begin
            chk("grant", 32'(grant), mb ? 32'(1 << mw) : 32'd0);
            chk("done", 32'(done), (mb && mc == mlen - 1) ? 32'(1 << mw) : 32'd0);
            chk("busy", 32'(busy), 32'(mb));
            chk("write_n", 32'(m_write_n), 32'(!(mb && !mskip && mc == 0)));
            chk("chipselect", 32'(m_chipselect),
                32'((mb && !mskip && mc == 0) || (RBX > 0 && mb && !mskip && mc == 1)));
            chk("address", 32'(m_address), 32'd0);
            chk("cur_type", 32'(cur_type), (mb && !mskip && mc == 0) ? 32'(mprev) : 32'(mcur));
            if (mb && !mskip && mc == 0) chk("writedata", m_writedata, {30'd0, mt});
`ifdef ESPTYPE_ARB_READBACK_EN
            chk("rb_error", 32'(rb_error), 32'(mrb));
`endif
            if (!m_write_n) begin
                wr_log.push_back(m_writedata);
                wr_cyc = cyc;
            end
            if (|done) begin
                done_log.push_back(32'(done));
                done_cyc = cyc;
            end
        end
    end

    task automatic serve(input int idx, input string n);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk); #1;
            if (done[idx]) begin
                req[idx] = 1'b0;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            timeout_fail(n);
            req[idx] = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    int n0, nd, nwr, bd, bw;
    int wb_cyc, db_cyc;
    logic [31:0] wb_dat, db_val;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur", 32'(cur_type), 32'd0);
        chk("rst_cs", 32'(m_chipselect), 32'd0);
        chk("rst_wn", 32'(m_write_n), 32'd1);
        chk("rst_wd", m_writedata, 32'd0);
        #1 reset = 1'b0;

        // Single change to type 2 on requester 0.
        @(negedge clk); #1;
        n0 = cyc;
        req_type[1:0] = 2'b10;
        req[0] = 1'b1;
        serve(0, "t1_done");
        chk("t1_wr_cyc", 32'(wr_cyc), 32'(n0 + 1));
        chk("t1_wdata", wr_log[$], 32'h2);
        chk("t1_done_cyc", 32'(done_cyc), 32'(n0 + 2 + S + RBX));
        chk("t1_done_val", done_log[$], 32'h1);
        @(negedge clk); #1;
        chk("t1_cur", 32'(cur_type), 32'h2);

        // Same type again: no write, done one cycle later.
        n0 = cyc;
        nwr = wr_log.size();
        req[0] = 1'b1;
        serve(0, "t2_done");
        chk("t2_done_cyc", 32'(done_cyc), 32'(n0 + 1));
        chk("t2_no_write", 32'(wr_log.size()), 32'(nwr));
        repeat (2) @(negedge clk);

        // Both held: grants and writes alternate.
        pulse_reset();
        bd = done_log.size();
        bw = wr_log.size();
        req_type = 4'b1101;
        req = 2'b11;
        for (int i = 0; i < 300 && req != 0; i++) begin
            @(negedge clk); #1;
            if (done_log.size() >= bd + 4) req = req & ~done;
        end
        if (req != 0) begin
            timeout_fail("t3_alternate");
            req = '0;
        end
        if (done_log.size() >= bd + 4 && wr_log.size() >= bw + 4) begin
            chk("t3_grant0", done_log[bd], 32'h1);
            chk("t3_grant1", done_log[bd+1], 32'h2);
            chk("t3_grant2", done_log[bd+2], 32'h1);
            chk("t3_grant3", done_log[bd+3], 32'h2);
            chk("t3_wr0", wr_log[bw], 32'h1);
            chk("t3_wr1", wr_log[bw+1], 32'h3);
            chk("t3_wr2", wr_log[bw+2], 32'h1);
            chk("t3_wr3", wr_log[bw+3], 32'h3);
        end else begin
            timeout_fail("t3_count");
        end
        repeat (2) @(negedge clk);

        // Reset during settle aborts without done, then the request restarts.
        pulse_reset();
        nwr = wr_log.size();
        req_type[1:0] = 2'b01;
        req[0] = 1'b1;
        for (int i = 0; i < 10 && wr_log.size() == nwr; i++) begin
            @(negedge clk); #1;
        end
        if (wr_log.size() == nwr) timeout_fail("t4_write");
        repeat (2 + RBX) @(negedge clk);
        nd = done_log.size();
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("t4_grant", 32'(grant), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_cur", 32'(cur_type), 32'd0);
        chk("t4_cs", 32'(m_chipselect), 32'd0);
        chk("t4_wn", 32'(m_write_n), 32'd1);
        chk("t4_wd", m_writedata, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("t4_no_done", 32'(done_log.size()), 32'(nd));
        reset = 1'b0;
        n0 = cyc;
        serve(0, "t4_restart");
        chk("t4_done_cyc", 32'(done_cyc), 32'(n0 + 2 + S + RBX));
        chk("t4_wdata", wr_log[$], 32'h1);
        chk("t4_done_count", 32'(done_log.size()), 32'(nd + 1));
        repeat (2) @(negedge clk);

        // Zero settle interval on a second instance, requester 1.
        @(negedge clk); #1;
        n0 = cyc;
        wb_cyc = -1; wb_dat = 0; db_cyc = -1; db_val = 0;
        type_b = 4'b0100;
        req_b = 2'b10;
        for (int i = 0; i < 20 && db_cyc < 0; i++) begin
            @(negedge clk); #1;
            if (!wn_b) begin
                wb_cyc = cyc;
                wb_dat = wd_b;
            end
            if (|done_b) begin
                db_cyc = cyc;
                db_val = 32'(done_b);
                req_b = '0;
            end
        end
        if (db_cyc < 0) timeout_fail("t5_done");
        chk("t5_wr_cyc", 32'(wb_cyc), 32'(n0 + 1));
        chk("t5_wdata", wb_dat, 32'h1);
        chk("t5_done_cyc", 32'(db_cyc), 32'(n0 + 2 + RBX));
        chk("t5_done_val", db_val, 32'h2);

`ifdef ESPTYPE_ARB_READBACK_EN
        // Corrupted readback sets the sticky error; sequencing continues.
        rb_fault = 1'b1;
        @(negedge clk); #1;
        n0 = cyc;
        req_type[3:2] = 2'b11;
        req[1] = 1'b1;
        serve(1, "t6_done");
        chk("t6_done_cyc", 32'(done_cyc), 32'(n0 + 4 + S));
        chk("t6_rb_error", 32'(rb_error), 32'd1);
        rb_fault = 1'b0;
        @(negedge clk); #1;
        req_type[1:0] = 2'b10;
        req[0] = 1'b1;
        serve(0, "t6_second");
        chk("t6_rb_sticky", 32'(rb_error), 32'd1);
        chk("t6_b_clean", 32'(rb_err_b), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
